// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared types and sizes for the UART command link; CMD_CHECKSUM_EN adds a fourth check byte.
package uart_cmd_pkg;
    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
    localparam int FRAME_BITS = 10;
`ifdef CMD_CHECKSUM_EN
    localparam int CMD_BYTES = 4;
`else
    localparam int CMD_BYTES = 3;
`endif
    localparam int BYTE_CNT_W = $clog2(CMD_BYTES);

    function automatic logic [7:0] cmd_byte(input logic [23:0] c, input logic [BYTE_CNT_W-1:0] i);
`ifdef CMD_CHECKSUM_EN
        logic [7:0] sum;
        sum = c[23:16] + c[15:8] + c[7:0];
        if (i == BYTE_CNT_W'(3))
            return ~sum;
`endif
        return i == BYTE_CNT_W'(0) ? c[23:16] : i == BYTE_CNT_W'(1) ? c[15:8] : c[7:0];
    endfunction
endpackage

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serializer; trmt is taken when idle or in the closing cycle of a stop bit.
module uart_tx
    import uart_cmd_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done
);
    localparam int BW = $clog2(BAUD_DIV);

    logic [BW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [8:0]    shift_q, shift_d;
    logic          active_q, active_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    assign bit_end = active_q && baud_q == BW'(BAUD_DIV - 1);
    assign tx_done = bit_end && bit_q == 4'(FRAME_BITS - 1);
    assign TX      = tx_q;

    always_comb begin
        baud_d   = active_q && !bit_end ? baud_q + 1'b1 : '0;
        bit_d    = bit_end ? bit_q + 1'b1 : bit_q;
        shift_d  = bit_end ? {1'b1, shift_q[8:1]} : shift_q;
        tx_d     = tx_done ? 1'b1 : bit_end ? shift_q[0] : tx_q;
        active_d = active_q && !tx_done;
        // loading in the stop bit's last cycle lets frames abut with no idle gap
        if (trmt && (!active_q || tx_done)) begin
            baud_d   = '0;
            bit_d    = '0;
            shift_d  = {1'b1, tx_data};
            tx_d     = 1'b0;
            active_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '1;
            active_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            active_q <= active_d;
            tx_q     <= tx_d;
        end
    end
endmodule

// File: rtl/uart_cmd_send.sv
// uart_cmd_send: sends a 24-bit command as 8N1 bytes, MSB byte first; CMD_CHECKSUM_EN appends a check byte.
module uart_cmd_send
    import uart_cmd_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        send_cmd,
    input  logic [23:0] cmd,
    output logic        TX,
    output logic        busy,
    output logic        cmd_sent
);
    state_t                state_q, state_d;
    logic [23:0]           cmd_q, cmd_d;
    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  sent_q, sent_d;
    logic                  trmt, tx_done, last, accept;
    logic [7:0]            tx_data;

    assign last   = cnt_q == BYTE_CNT_W'(CMD_BYTES - 1);
    assign accept = send_cmd && (state_q == IDLE || (state_q == WAIT && tx_done && last));
    // the first byte goes straight from the input so its start bit follows acceptance at once
    assign trmt    = accept || state_q == SEND;
    assign tx_data = accept ? cmd[23:16] : cmd_byte(cmd_q, cnt_q);

    assign busy     = busy_q;
    assign cmd_sent = sent_q;

    uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (trmt),
        .tx_data (tx_data),
        .TX      (TX),
        .tx_done (tx_done)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = accept ? cmd : cmd_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        sent_d  = sent_q;
        if (accept) begin
            state_d = SEND;
            cnt_d   = '0;
            busy_d  = 1'b1;
            sent_d  = 1'b0;
        end else if (state_q == SEND) begin
            state_d = WAIT;
        end else if (state_q == WAIT && tx_done) begin
            state_d = last ? IDLE : SEND;
            cnt_d   = last ? cnt_q : cnt_q + 1'b1;
            busy_d  = !last;
            sent_d  = last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            sent_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            sent_q  <= sent_d;
        end
    end
endmodule

// File: tb/tb_uart_cmd_send.sv
// tb_uart_cmd_send: directed bench for uart_cmd_send at BAUD_DIV=16.
module tb_uart_cmd_send;
    localparam int B = 16;
`ifdef CMD_CHECKSUM_EN
    localparam int NB   = 4;
    localparam int DONE = 40 * B + 3;
`else
    localparam int NB   = 3;
    localparam int DONE = 30 * B + 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        send_cmd = 1'b0;
    logic [23:0] cmd = '0;
    logic        TX, busy, cmd_sent;
    int          total = 0, passed = 0, cyc = 0, acc = 0;

    uart_cmd_send #(.BAUD_DIV(B)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .send_cmd (send_cmd),
        .cmd      (cmd),
        .TX       (TX),
        .busy     (busy),
        .cmd_sent (cmd_sent)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // entered at the negedge in a frame's first cycle; leaves at the first stop-bit sample
    task automatic expect_frame(input logic [7:0] exp, input string tag, input bit poke, output logic [7:0] b);
        check({tag, " start"}, TX, 0);
        for (int k = 0; k < 8; k++) begin
            if (poke && k == 4) begin
                send_cmd = 1'b1;
                cmd = 24'h123456;
                @(negedge clk);
                send_cmd = 1'b0;
                repeat (B - 1) @(negedge clk);
            end else begin
                repeat (B) @(negedge clk);
            end
            b[k] = TX;
        end
        check({tag, " busy"}, busy, 1);
        repeat (B) @(negedge clk);
        check({tag, " stop"}, TX, 1);
        check({tag, " byte"}, b, exp);
    endtask

    task automatic xfer(input logic [31:0] bytes, input bit poke);
        logic [7:0]  b;
        logic [23:0] rx;
        rx = '0;
        acc = cyc;
        check("busy after accept", busy, 1);
        check("sent cleared", cmd_sent, 0);
        for (int f = 0; f < NB; f++) begin
            expect_frame(bytes[31-8*f -: 8], $sformatf("frame%0d", f), poke && f == 1, b);
            if (f < 3) rx = {rx[15:0], b};
            if (f < NB - 1) begin
                repeat (B) @(negedge clk);
                check("gap TX", TX, 1);
                check("gap busy", busy, 1);
                @(negedge clk);
            end
        end
        check("loopback cmd", rx, bytes[31:8]);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3 * B && !cmd_sent; i++) @(negedge clk);
        check("done latency", cyc - acc, DONE);
        check("done busy", busy, 0);
        check("done sent", cmd_sent, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst TX", TX, 1);
        check("rst busy", busy, 0);
        check("rst sent", cmd_sent, 0);
        rst_n = 1'b1;
        @(negedge clk);
        cmd = 24'h55AAE3;
        send_cmd = 1'b1;
        @(negedge clk);
        send_cmd = 1'b0;
        xfer(32'h55AAE31D, 1'b1);
        wait_done();
        repeat (50) @(negedge clk);
        check("no retx busy", busy, 0);
        check("no retx sent", cmd_sent, 1);
        check("no retx TX", TX, 1);
        cmd = 24'hFF0001;
        send_cmd = 1'b1;
        @(negedge clk);
        xfer(32'hFF0001FF, 1'b0);
        repeat (B) @(negedge clk);
        check("b2b accept edge", cyc - acc, DONE);
        check("b2b sent low", cmd_sent, 0);
        check("b2b busy", busy, 1);
        send_cmd = 1'b0;
        xfer(32'hFF0001FF, 1'b0);
        wait_done();
        @(negedge clk);
        cmd = 24'hA500C3;
        send_cmd = 1'b1;
        @(negedge clk);
        send_cmd = 1'b0;
        repeat (10 * B + 1 + 3 * B) @(negedge clk);
        check("pre-reset TX", TX, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async rst TX", TX, 1);
        check("async rst busy", busy, 0);
        check("async rst sent", cmd_sent, 0);
        check("async rst fsm", dut.state_q, uart_cmd_pkg::IDLE);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cmd = 24'h3C5A96;
        send_cmd = 1'b1;
        @(negedge clk);
        send_cmd = 1'b0;
        xfer(32'h3C5A96D3, 1'b0);
        wait_done();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
